// File: rtl/parking_fee_unit_if.sv
// parking_fee_unit_if: entry, exit, coin and payment signals of the parking fee unit
interface parking_fee_unit_if #(
    parameter int IW = 3,
    parameter int CW = 16
);
    logic          entry_evt;
    logic          exit_req;
    logic [IW-1:0] exit_id;
    logic          coin_vld;
    logic [7:0]    coin_val;
    logic          ticket_vld;
    logic [IW-1:0] ticket_id;
    logic          full;
    logic [IW:0]   free_cnt;
    logic [CW-1:0] cost;
    logic          cost_vld;
    logic          pay;
    logic [CW-1:0] change;
    logic          err;
    modport master (
        output entry_evt, exit_req, exit_id, coin_vld, coin_val,
        input  ticket_vld, ticket_id, full, free_cnt, cost, cost_vld, pay, change, err
    );
    modport slave (
        input  entry_evt, exit_req, exit_id, coin_vld, coin_val,
        output ticket_vld, ticket_id, full, free_cnt, cost, cost_vld, pay, change, err
    );
endinterface

// File: rtl/parking_fee_unit.sv
// parking_fee_unit: ticket issue, elapsed-time fee calculation and coin payment for the car-park exit
module parking_fee_unit #(
    parameter int PMAX = 5,
    parameter int IW = 3,
    parameter int TICKS_PER_UNIT = 1000,
    parameter int RATE = 2,
    parameter int TW = 16,
    parameter int CW = 16
) (
    input logic clk,
    input logic rst,
    parking_fee_unit_if.slave bus
);
    localparam int PW = $clog2(TICKS_PER_UNIT);
    localparam int NS = 2 ** IW;
    localparam int MW = TW + 33;
    typedef enum logic [1:0] {IDLE, CALC, WAIT, PAID} state_t;
    state_t        state;
    logic [PW-1:0] pre;
    logic [TW-1:0] now;
    logic [TW-1:0] etime [PMAX];
    logic [PMAX-1:0] occ, occ_n;
    logic [NS-1:0] occ_x;
    logic [IW-1:0] id, slot;
    logic [IW:0]   used;
    logic [CW-1:0] credit, sum, fee_sat;
    logic [CW:0]   raw;
    logic [TW:0]   units;
    logic [MW-1:0] fee;
    logic          take, id_ok, wrap;
    always_comb begin
        slot = '0;
        used = '0;
        for (int i = PMAX - 1; i >= 0; i--) begin
            if (!occ[i]) slot = IW'(i);
            used = used + (IW+1)'(occ[i]);
        end
    end
    // entry sees the table before any release happening in the same cycle
    always_comb begin
        occ_n = occ;
        if (state == PAID) occ_n[id] = 1'b0;
        if (take) occ_n[slot] = 1'b1;
    end
    assign occ_x        = NS'(occ);
    assign bus.full     = &occ;
    assign bus.free_cnt = (IW+1)'(PMAX) - used;
    assign take         = bus.entry_evt && !bus.full;
    assign id_ok        = (int'(bus.exit_id) < PMAX) && occ_x[bus.exit_id];
    assign wrap         = pre == PW'(TICKS_PER_UNIT - 1);
    assign units        = {1'b0, TW'(now - etime[id])} + (TW+1)'(1);
    assign fee          = MW'(units) * MW'(RATE);
    assign fee_sat      = (fee > MW'({CW{1'b1}})) ? '1 : CW'(fee);
    assign raw          = {1'b0, credit} + (CW+1)'(bus.coin_val);
    assign sum          = raw[CW] ? '1 : raw[CW-1:0];
    always_ff @(posedge clk) begin
        if (take) etime[slot] <= now;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            pre            <= '0;
            now            <= '0;
            occ            <= '0;
            id             <= '0;
            credit         <= '0;
            bus.ticket_vld <= 1'b0;
            bus.ticket_id  <= '0;
            bus.cost       <= '0;
            bus.cost_vld   <= 1'b0;
            bus.pay        <= 1'b0;
            bus.change     <= '0;
            bus.err        <= 1'b0;
        end else begin
            pre            <= wrap ? '0 : pre + PW'(1);
            now            <= wrap ? now + TW'(1) : now;
            occ            <= occ_n;
            bus.ticket_vld <= take;
            bus.ticket_id  <= take ? slot : bus.ticket_id;
            bus.err        <= 1'b0;
            bus.pay        <= 1'b0;
            case (state)
                IDLE: if (bus.exit_req) begin
                    if (id_ok) begin
                        state      <= CALC;
                        id         <= bus.exit_id;
                        bus.change <= '0;
                    end else begin
                        bus.err <= 1'b1;
                    end
                end
                CALC: begin
                    bus.cost     <= fee_sat;
                    bus.cost_vld <= 1'b1;
                    credit       <= '0;
                    state        <= WAIT;
                end
                WAIT: if (bus.coin_vld) begin
                    credit <= sum;
                    if (sum >= bus.cost) begin
                        bus.pay      <= 1'b1;
                        bus.cost_vld <= 1'b0;
                        bus.change   <= sum - bus.cost;
                        state        <= PAID;
                    end
                end
                PAID: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_parking_fee_unit.sv
// tb_parking_fee_unit: directed scenarios with a queue scoreboard checked by a separate monitor
module tb_parking_fee_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   tq[$];
    int   cq[$];
    int   pq[$];
    int   eq[$];
    parking_fee_unit_if #(.IW(3), .CW(16)) bus();
    // a 4-bit timebase makes the unit-counter wrap reachable in a short run
    parking_fee_unit #(
        .PMAX(5), .IW(3), .TICKS_PER_UNIT(4), .RATE(2), .TW(4), .CW(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= rst ? cyc + 1 : 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int e, input bit ent, input bit ex, input int id, input bit cv, input int val);
        while (cyc < e - 1) @(negedge clk);
        bus.entry_evt = ent;
        bus.exit_req  = ex;
        bus.exit_id   = 3'(id);
        bus.coin_vld  = cv;
        bus.coin_val  = 8'(val);
        @(posedge clk);
        #1;
        bus.entry_evt = 1'b0;
        bus.exit_req  = 1'b0;
        bus.coin_vld  = 1'b0;
    endtask

    task automatic entry(input int e);
        drive(e, 1'b1, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic leave(input int e, input int id);
        drive(e, 1'b0, 1'b1, id, 1'b0, 0);
    endtask

    task automatic coin(input int e, input int v);
        drive(e, 1'b0, 1'b0, 0, 1'b1, v);
    endtask

    task automatic upto(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.entry_evt = 1'b0;
        bus.exit_req  = 1'b0;
        bus.exit_id   = '0;
        bus.coin_vld  = 1'b0;
        bus.coin_val  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst ticket_vld", 32'(bus.ticket_vld), 0);
        chk("rst ticket_id", 32'(bus.ticket_id), 0);
        chk("rst full", 32'(bus.full), 0);
        chk("rst free_cnt", 32'(bus.free_cnt), 5);
        chk("rst cost", 32'(bus.cost), 0);
        chk("rst cost_vld", 32'(bus.cost_vld), 0);
        chk("rst pay", 32'(bus.pay), 0);
        chk("rst change", 32'(bus.change), 0);
        chk("rst err", 32'(bus.err), 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bit cv_d;
        int x;
        cv_d = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.ticket_vld) begin
                n_vec++;
                if (tq.size() == 0) begin
                    n_bad++;
                    $display("FAIL ticket: unexpected ticket_vld with id %0d, expected none", bus.ticket_id);
                end else begin
                    x = tq.pop_front();
                    if (32'(bus.ticket_id) != x) begin
                        n_bad++;
                        $display("FAIL ticket_id: got %0d, expected %0d", bus.ticket_id, x);
                    end
                end
            end
            if (bus.cost_vld && !cv_d) begin
                n_vec++;
                if (cq.size() == 0) begin
                    n_bad++;
                    $display("FAIL cost: unexpected cost_vld with cost %0d, expected none", bus.cost);
                end else begin
                    x = cq.pop_front();
                    if (32'(bus.cost) != x) begin
                        n_bad++;
                        $display("FAIL cost: got %0d, expected %0d", bus.cost, x);
                    end
                end
            end
            cv_d = bus.cost_vld;
            if (bus.pay) begin
                n_vec++;
                if (pq.size() == 0) begin
                    n_bad++;
                    $display("FAIL pay: unexpected pay with change %0d, expected none", bus.change);
                end else begin
                    x = pq.pop_front();
                    if (32'(bus.change) != x) begin
                        n_bad++;
                        $display("FAIL change: got %0d, expected %0d", bus.change, x);
                    end
                end
            end
            if (bus.err) begin
                n_vec++;
                if (eq.size() == 0) begin
                    n_bad++;
                    $display("FAIL err: got 1, expected 0");
                end else begin
                    x = eq.pop_front();
                end
            end
        end
    end

    initial begin
        // single ticket, fee for six started units, payment with change
        do_reset();
        tq.push_back(0);
        entry(10);
        chk("A free_cnt", 32'(bus.free_cnt), 4);
        chk("A full", 32'(bus.full), 0);
        cq.push_back(12);
        leave(30, 0);
        upto(31);
        chk("A cost_vld", 32'(bus.cost_vld), 1);
        chk("A cost", 32'(bus.cost), 12);
        coin(33, 5);
        coin(35, 5);
        pq.push_back(3);
        coin(37, 5);
        chk("A pay", 32'(bus.pay), 1);
        chk("A free during pay", 32'(bus.free_cnt), 4);
        upto(38);
        chk("A free after pay", 32'(bus.free_cnt), 5);
        chk("A pay one cycle", 32'(bus.pay), 0);
        chk("A cost_vld cleared", 32'(bus.cost_vld), 0);

        // fill the park, drop the sixth car and a car arriving during release
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tq.push_back(i);
            entry(2 + i);
        end
        chk("B full", 32'(bus.full), 1);
        chk("B free_cnt", 32'(bus.free_cnt), 0);
        entry(7);
        chk("B full kept", 32'(bus.full), 1);
        chk("B free kept", 32'(bus.free_cnt), 0);
        cq.push_back(6);
        leave(8, 2);
        pq.push_back(4);
        coin(10, 10);
        entry(11);
        chk("B drop on release free", 32'(bus.free_cnt), 1);
        chk("B drop on release full", 32'(bus.full), 0);
        tq.push_back(2);
        entry(12);
        chk("B reuse free", 32'(bus.free_cnt), 0);
        chk("B reuse full", 32'(bus.full), 1);

        // bad ids, entry together with exit, inputs ignored outside their states
        do_reset();
        tq.push_back(0);
        entry(2);
        eq.push_back(1);
        leave(4, 7);
        chk("C err range", 32'(bus.err), 1);
        eq.push_back(1);
        leave(6, 3);
        chk("C err free slot", 32'(bus.err), 1);
        upto(8);
        chk("C no cost_vld", 32'(bus.cost_vld), 0);
        tq.push_back(1);
        cq.push_back(6);
        drive(9, 1'b1, 1'b1, 0, 1'b0, 0);
        coin(10, 50);
        drive(11, 1'b0, 1'b1, 1, 1'b1, 3);
        pq.push_back(0);
        coin(12, 3);
        upto(14);
        chk("C free after pay", 32'(bus.free_cnt), 4);

        // entry at now=14, exit at now=1 across the timebase wrap
        do_reset();
        tq.push_back(0);
        entry(57);
        cq.push_back(8);
        leave(68, 0);
        pq.push_back(192);
        coin(70, 200);

        // reset during WAIT discards the payment and the ticket table
        do_reset();
        tq.push_back(0);
        entry(2);
        cq.push_back(8);
        leave(12, 0);
        coin(15, 5);
        upto(16);
        do_reset();
        eq.push_back(1);
        leave(3, 0);
        coin(5, 200);
        upto(8);
        chk("E free_cnt", 32'(bus.free_cnt), 5);
        chk("E cost_vld", 32'(bus.cost_vld), 0);

        repeat (4) @(negedge clk);
        #1;
        chk("pending tickets", tq.size(), 0);
        chk("pending costs", cq.size(), 0);
        chk("pending pays", pq.size(), 0);
        chk("pending errs", eq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
